// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch PC, bus request issue and in-order prefetch queue
module ifu_prefetch #(
  parameter int          DEPTH       = 2,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          STALL_WIDTH = 6,
  parameter int          STALL_ID    = 1,
  parameter logic [31:0] INST_NOP    = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic [31:0]            jump_addr_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  output logic                   ibus_req_o,
  output logic [31:0]            ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [31:0]            ibus_rdata_i,
  output logic [31:0]            inst_o,
  output logic [31:0]            inst_addr_o,
  output logic                   inst_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [PW:0] LIM = (PW + 1)'(DEPTH);

  logic [31:0]      r_pc;
  logic [PW-1:0]    r_alloc;
  logic [PW-1:0]    r_fill;
  logic [PW-1:0]    r_rd;
  logic [DW-1:0]    r_drop;
  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_outst;
  logic [PW:0]   w_need;
  logic [AW-1:0] w_head;
  logic          w_req;
  logic          w_alloc;
  logic          w_fill;
  logic          w_valid;
  logic          w_pop;
  logic          w_unused;

  assign w_occ    = r_alloc - r_rd;
  assign w_outst  = r_alloc - r_fill;
  // Responses still owed to a flushed stream keep their slot budget until they drain.
  assign w_need   = {1'b0, w_occ} + (PW + 1)'(r_drop);
  assign w_head   = r_rd[AW-1:0];
  assign w_req    = !rst && !jump_flag_i && (w_need < LIM);
  assign w_alloc  = w_req && ibus_gnt_i;
  assign w_fill   = ibus_rvalid_i && (r_drop == '0) && !jump_flag_i;
  assign w_valid  = (w_occ != '0) && r_filled[w_head];
  assign w_pop    = w_valid && !stall_i[STALL_ID] && !jump_flag_i;
  assign w_unused = ^{stall_i, jump_addr_i[1:0]};

  assign ibus_req_o   = w_req;
  assign ibus_addr_o  = r_pc;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_data[w_head] : INST_NOP;
  assign inst_addr_o  = w_valid ? r_addr[w_head] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_alloc  <= '0;
      r_fill   <= '0;
      r_rd     <= '0;
      r_drop   <= '0;
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (jump_flag_i) begin
      r_pc     <= {jump_addr_i[31:2], 2'b00};
      r_alloc  <= '0;
      r_fill   <= '0;
      r_rd     <= '0;
      r_filled <= '0;
      r_drop   <= r_drop + DW'(w_outst) - DW'(ibus_rvalid_i);
    end else begin
      if (w_alloc) begin
        r_addr[r_alloc[AW-1:0]]   <= r_pc;
        r_filled[r_alloc[AW-1:0]] <= 1'b0;
        r_alloc                   <= r_alloc + PW'(1);
        r_pc                      <= r_pc + 32'd4;
      end
      if (w_fill) begin
        r_data[r_fill[AW-1:0]]   <= ibus_rdata_i;
        r_filled[r_fill[AW-1:0]] <= 1'b1;
        r_fill                   <= r_fill + PW'(1);
      end
      if (ibus_rvalid_i && (r_drop != '0)) begin
        r_drop <= r_drop - DW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
    end
  end

  a_rvalid_owed: assert property (@(posedge clk) disable iff (rst)
    ibus_rvalid_i |-> ((r_drop != '0) || (w_outst != '0)));
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    r_drop <= DW'(DEPTH));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed checks of ifu_prefetch against a latency-configurable memory
module tb_ifu_prefetch;

  localparam int          STALL_WIDTH = 6;
  localparam int          STALL_ID    = 1;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   jump_flag_i = 1'b0;
  logic [31:0]            jump_addr_i = 32'h0;
  logic [STALL_WIDTH-1:0] stall_i = '0;
  logic                   ibus_req_o;
  logic [31:0]            ibus_addr_o;
  logic                   ibus_gnt_i = 1'b0;
  logic                   ibus_rvalid_i = 1'b0;
  logic [31:0]            ibus_rdata_i = 32'h0;
  logic [31:0]            inst_o;
  logic [31:0]            inst_addr_o;
  logic                   inst_valid_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_en = 1'b1;
  logic [31:0] pq_addr[$];
  int          pq_due[$];

  ifu_prefetch #(
    .DEPTH(2), .RESET_PC(32'h0), .STALL_WIDTH(STALL_WIDTH), .STALL_ID(STALL_ID), .INST_NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .stall_i(stall_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ibus_gnt_i = gnt_en;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mdata(pq_addr[0]);
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic tick();
    if (ibus_req_o && ibus_gnt_i) begin
      pq_addr.push_back(ibus_addr_o);
      pq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_valid, input logic [31:0] exp_iaddr);
    drive();
    chk({tag, ".req"}, {31'b0, ibus_req_o}, {31'b0, exp_req});
    if (exp_req) chk({tag, ".addr"}, ibus_addr_o, exp_addr);
    chk({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, exp_valid});
    chk({tag, ".iaddr"}, inst_addr_o, exp_valid ? exp_iaddr : 32'h0);
    chk({tag, ".inst"}, inst_o, exp_valid ? mdata(exp_iaddr) : NOP);
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    ibus_rvalid_i = 1'b0;
    ibus_gnt_i = 1'b0;
    pq_addr.delete();
    pq_due.delete();
    @(posedge clk);
    #1;
    chk({tag, ".rst_req"}, {31'b0, ibus_req_o}, 32'h0);
    chk({tag, ".rst_valid"}, {31'b0, inst_valid_o}, 32'h0);
    chk({tag, ".rst_inst"}, inst_o, NOP);
    chk({tag, ".rst_iaddr"}, inst_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    jump_flag_i = 1'b0;
    stall_i = '0;
    lat = 1;
    gnt_en = 1'b1;
  endtask

  initial begin
    // 1: streaming with single-cycle memory; non-ID stall bits must be ignored
    do_reset("t1");
    stall_i = '1;
    stall_i[STALL_ID] = 1'b0;
    step("t1c1", 1, 32'h0,  0, 32'h0);
    step("t1c2", 1, 32'h4,  0, 32'h0);
    step("t1c3", 0, 32'h8,  1, 32'h0);
    step("t1c4", 1, 32'h8,  1, 32'h4);
    step("t1c5", 1, 32'hC,  0, 32'h0);
    step("t1c6", 0, 32'h10, 1, 32'h8);
    step("t1c7", 1, 32'h10, 1, 32'hC);

    // 2: six-cycle ID stall holds the head and fills the queue
    do_reset("t2");
    stall_i[STALL_ID] = 1'b1;
    step("t2c1", 1, 32'h0, 0, 32'h0);
    step("t2c2", 1, 32'h4, 0, 32'h0);
    step("t2c3", 0, 32'h8, 1, 32'h0);
    step("t2c4", 0, 32'h8, 1, 32'h0);
    step("t2c5", 0, 32'h8, 1, 32'h0);
    step("t2c6", 0, 32'h8, 1, 32'h0);
    stall_i[STALL_ID] = 1'b0;
    step("t2c7", 0, 32'h8, 1, 32'h0);
    step("t2c8", 1, 32'h8, 1, 32'h4);
    step("t2c9", 1, 32'hC, 0, 32'h0);
    step("t2c10", 0, 32'h10, 1, 32'h8);

    // 3: two-cycle memory, flush with both requests outstanding
    do_reset("t3");
    lat = 2;
    step("t3c1", 1, 32'h0, 0, 32'h0);
    step("t3c2", 1, 32'h4, 0, 32'h0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    step("t3c3", 0, 32'h0, 0, 32'h0);
    jump_flag_i = 1'b0;
    step("t3c4", 1, 32'h100, 0, 32'h0);
    step("t3c5", 1, 32'h104, 0, 32'h0);
    step("t3c6", 0, 32'h0,   0, 32'h0);
    step("t3c7", 0, 32'h0,   1, 32'h100);
    step("t3c8", 1, 32'h108, 1, 32'h104);

    // 4: flush in the same cycle as an rvalid and a would-be pop
    do_reset("t4");
    step("t4c1", 1, 32'h0, 0, 32'h0);
    step("t4c2", 1, 32'h4, 0, 32'h0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    step("t4c3", 0, 32'h0, 1, 32'h0);
    jump_flag_i = 1'b0;
    step("t4c4", 1, 32'h200, 0, 32'h0);
    step("t4c5", 1, 32'h204, 0, 32'h0);
    step("t4c6", 0, 32'h0,   1, 32'h200);

    // 5: grant withheld for five cycles at pc 0x8
    do_reset("t5");
    step("t5c1", 1, 32'h0, 0, 32'h0);
    step("t5c2", 1, 32'h4, 0, 32'h0);
    step("t5c3", 0, 32'h8, 1, 32'h0);
    gnt_en = 1'b0;
    step("t5c4", 1, 32'h8, 1, 32'h4);
    step("t5c5", 1, 32'h8, 0, 32'h0);
    step("t5c6", 1, 32'h8, 0, 32'h0);
    step("t5c7", 1, 32'h8, 0, 32'h0);
    step("t5c8", 1, 32'h8, 0, 32'h0);
    gnt_en = 1'b1;
    step("t5c9",  1, 32'h8, 0, 32'h0);
    step("t5c10", 1, 32'hC, 0, 32'h0);
    step("t5c11", 0, 32'h0, 1, 32'h8);

    // 6: misaligned jump target, then reset in the middle of a burst
    do_reset("t6");
    step("t6c1", 1, 32'h0, 0, 32'h0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    step("t6c2", 0, 32'h0, 0, 32'h0);
    jump_flag_i = 1'b0;
    step("t6c3", 1, 32'h100, 0, 32'h0);
    step("t6c4", 1, 32'h104, 0, 32'h0);
    step("t6c5", 0, 32'h0,   1, 32'h100);
    rst = 1'b1;
    ibus_rvalid_i = 1'b0;
    #1;
    chk("t6.async_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("t6.async_inst", inst_o, NOP);
    chk("t6.async_req", {31'b0, ibus_req_o}, 32'h0);
    do_reset("t6r");
    step("t6c6", 1, 32'h0, 0, 32'h0);
    step("t6c7", 1, 32'h4, 0, 32'h0);
    step("t6c8", 0, 32'h0, 1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
